// File: rtl/sgd_gradient_scheduler.sv
// Gradient read sequencer: queues dot-product-ready samples and issues fifo_a bursts of chunks x bits pops.
// Optional stall counter enabled by defining SGD_GSCHED_PERF_EN.
module sgd_gradient_scheduler #(
  parameter int DIM_SHIFT  = 9,
  parameter int PEND_DEPTH = 4,
  parameter int MAX_BITS   = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        started,
  input  logic [31:0] number_of_epochs,
  input  logic [31:0] number_of_samples,
  input  logic [31:0] dimension,
  input  logic [31:0] number_of_bits,
  input  logic        sample_valid,
  output logic        sample_ready,
  input  logic        fifo_a_empty,
  output logic        fifo_a_rd_en,
  output logic [4:0]  bit_index,
  output logic [11:0] chunk_index,
  output logic        first_bit,
  output logic        last_bit,
  output logic        sample_done,
  output logic        epoch_done,
  output logic        all_done,
  output logic        busy,
  output logic        overflow_err,
  output logic [31:0] stall_cycles
);

  localparam int PW = $clog2(PEND_DEPTH + 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WAIT, S_RUN, S_DONE} state_t;
  state_t state_q, state_d;

  logic          started_q;
  logic [PW-1:0] pend_q, pend_d;
  logic [4:0]    bit_q, nbits_q, nbits_in;
  logic [31:0]   chunk_q, samp_q, epoch_q;
  logic [31:0]   chunks_q, samples_q, epochs_q, chunks_in;
  logic          active, abort, room, accept, ovf_set, eligible, pop;
  logic          at_last_bit, at_last_chunk, smp_end, ep_end, run_end, cfg_zero;
  logic          unused_cfg_bits;

  assign unused_cfg_bits = ^number_of_bits[31:5];
  assign nbits_in  = (number_of_bits[4:0] == 5'd0 || number_of_bits[4:0] > 5'(MAX_BITS))
                     ? 5'(MAX_BITS) : number_of_bits[4:0];
  assign chunks_in = (dimension >> DIM_SHIFT) + {31'd0, |dimension[DIM_SHIFT-1:0]};
  assign cfg_zero  = (number_of_epochs == '0) || (number_of_samples == '0) || (dimension == '0);

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // A sample accepted while idle in WAIT may pop on the same edge, giving the one-cycle first-pop latency.
  always_comb begin
    active        = (state_q == S_WAIT) || (state_q == S_RUN);
    abort         = !started && (active || state_q == S_LOAD);
    room          = (pend_q != PW'(PEND_DEPTH));
    accept        = active && started && sample_valid && room;
    ovf_set       = active && sample_valid && !room;
    eligible      = !abort && ((state_q == S_RUN) ||
                               (state_q == S_WAIT && (pend_q != '0 || accept)));
    pop           = eligible && !fifo_a_empty;
    at_last_bit   = (bit_q == nbits_q - 5'd1);
    at_last_chunk = (chunk_q == chunks_q - 32'd1);
    smp_end       = pop && at_last_bit && at_last_chunk;
    ep_end        = smp_end && (samp_q + 32'd1 == samples_q);
    run_end       = ep_end && (epoch_q + 32'd1 == epochs_q);
    pend_d        = pend_q + PW'(accept) - PW'(smp_end);
    state_d       = state_q;
    case (state_q)
      S_IDLE: if (started && !started_q) state_d = S_LOAD;
      S_LOAD: begin
        if (abort)         state_d = S_IDLE;
        else if (cfg_zero) state_d = S_DONE;
        else               state_d = S_WAIT;
      end
      S_WAIT, S_RUN: begin
        if (abort)                state_d = S_IDLE;
        else if (run_end)         state_d = S_DONE;
        else if (pend_d != '0)    state_d = S_RUN;
        else                      state_d = S_WAIT;
      end
      S_DONE: if (!started) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (state_d != S_WAIT && state_d != S_RUN) pend_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      started_q    <= 1'b0;
      pend_q       <= '0;
      bit_q        <= '0;
      chunk_q      <= '0;
      samp_q       <= '0;
      epoch_q      <= '0;
      nbits_q      <= '0;
      chunks_q     <= '0;
      samples_q    <= '0;
      epochs_q     <= '0;
      sample_ready <= 1'b0;
      fifo_a_rd_en <= 1'b0;
      bit_index    <= '0;
      chunk_index  <= '0;
      first_bit    <= 1'b0;
      last_bit     <= 1'b0;
      sample_done  <= 1'b0;
      epoch_done   <= 1'b0;
      all_done     <= 1'b0;
      busy         <= 1'b0;
      overflow_err <= 1'b0;
    end else begin
      started_q    <= started;
      pend_q       <= pend_d;
      sample_ready <= (pend_d != PW'(PEND_DEPTH));
      fifo_a_rd_en <= pop;
      sample_done  <= smp_end;
      epoch_done   <= ep_end;
      all_done     <= (state_d == S_DONE);
      busy         <= (state_d == S_LOAD) || (state_d == S_WAIT) || (state_d == S_RUN);
      if (ovf_set) overflow_err <= 1'b1;
      if (pop) begin
        bit_index   <= bit_q;
        chunk_index <= chunk_q[11:0];
        first_bit   <= (bit_q == 5'd0);
        last_bit    <= at_last_bit;
      end
      if (state_q == S_LOAD) begin
        nbits_q   <= nbits_in;
        chunks_q  <= chunks_in;
        samples_q <= number_of_samples;
        epochs_q  <= number_of_epochs;
        bit_q     <= '0;
        chunk_q   <= '0;
        samp_q    <= '0;
        epoch_q   <= '0;
      end else if (state_d == S_IDLE) begin
        bit_q   <= '0;
        chunk_q <= '0;
        samp_q  <= '0;
        epoch_q <= '0;
      end else if (pop) begin
        if (at_last_bit) begin
          bit_q   <= '0;
          chunk_q <= at_last_chunk ? '0 : chunk_q + 32'd1;
        end else begin
          bit_q <= bit_q + 5'd1;
        end
        if (smp_end) begin
          samp_q  <= ep_end ? '0 : samp_q + 32'd1;
          epoch_q <= epoch_q + {31'd0, ep_end};
        end
      end
    end
  end

`ifdef SGD_GSCHED_PERF_EN
  logic stall;
  assign stall = eligible && fifo_a_empty;

  always_ff @(posedge clk) begin
    if (!rst_n)                                 stall_cycles <= '0;
    else if (state_q == S_LOAD)                 stall_cycles <= '0;
    else if (stall && stall_cycles != '1)       stall_cycles <= stall_cycles + 32'd1;
  end
`else
  assign stall_cycles = '0;
`endif

endmodule
